// File: rtl/axis_done_barrier_if.sv
// Handshake bundle between the G-code sequencer / step generators and the
// axis completion barrier. Signal names follow the block's port list.
interface axis_done_barrier_if #(
  parameter int N_CHANNELS    = 4,
  parameter int TIMEOUT_WIDTH = 24
);
  logic                     i_Start;
  logic [N_CHANNELS-1:0]    i_Enable;
  logic [N_CHANNELS-1:0]    i_Done;
  logic [TIMEOUT_WIDTH-1:0] i_TimeoutCycles;
  logic                     i_Ack;
  logic                     i_Abort;
  logic                     o_Busy;
  logic                     o_AllDone;
  logic                     o_Timeout;
  logic [N_CHANNELS-1:0]    o_Pending;
  logic [N_CHANNELS-1:0]    o_DoneMask;

  // Sequencer / step-generator side.
  modport master (
    output i_Start, i_Enable, i_Done, i_TimeoutCycles, i_Ack, i_Abort,
    input  o_Busy, o_AllDone, o_Timeout, o_Pending, o_DoneMask
  );

  // Barrier side.
  modport slave (
    input  i_Start, i_Enable, i_Done, i_TimeoutCycles, i_Ack, i_Abort,
    output o_Busy, o_AllDone, o_Timeout, o_Pending, o_DoneMask
  );
endinterface

// File: rtl/axis_done_barrier.sv
// N-channel completion barrier: arms on start, collects per-axis done pulses
// into sticky flags under a per-move enable mask, and reports completion or a
// watchdog timeout through a held flag cleared by acknowledge.
module axis_done_barrier #(
  parameter int N_CHANNELS    = 4,
  parameter int TIMEOUT_WIDTH = 24
) (
  input logic                i_Clk,
  input logic                i_Rst_n,
  axis_done_barrier_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = TIMEOUT_WIDTH'(1);

  state_e                   state_q,  state_d;
  logic [N_CHANNELS-1:0]    mask_q,   mask_d;
  logic [N_CHANNELS-1:0]    sticky_q, sticky_d;
  logic [TIMEOUT_WIDTH-1:0] count_q,  count_d;
  logic [TIMEOUT_WIDTH-1:0] limit_q,  limit_d;

  logic [N_CHANNELS-1:0]    start_hits;
  logic [N_CHANNELS-1:0]    armed_hits;

  // Done bits that count toward completion this cycle, on the start edge and while armed.
  assign start_hits = bus.i_Done & bus.i_Enable;
  assign armed_hits = (sticky_q | bus.i_Done) & mask_q;

  // Next-state and next-register computation; abort overrides every state.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    mask_d   = mask_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    limit_d  = limit_q;

    if (bus.i_Abort) begin
      state_d  = ST_IDLE;
      mask_d   = '0;
      sticky_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_Start) begin
            mask_d   = bus.i_Enable;
            limit_d  = bus.i_TimeoutCycles;
            count_d  = '0;
            sticky_d = start_hits;
            // An empty mask, or every enabled axis already done, completes immediately.
            state_d  = (start_hits == bus.i_Enable) ? ST_DONE : ST_ARMED;
          end
        end
        ST_ARMED: begin
          sticky_d = sticky_q | (bus.i_Done & mask_q);
          if (count_q != '1) count_d = count_q + CNT_ONE;
          // Completion is tested first so it wins over a coincident timeout.
          if (armed_hits == mask_q) begin
            state_d = ST_DONE;
          end else if ((limit_q != '0) && (count_q == limit_q - CNT_ONE)) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          // Start is ignored here, even alongside ack; it must be reissued in IDLE.
          if (bus.i_Ack) begin
            state_d  = ST_IDLE;
            mask_d   = '0;
            sticky_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (!i_Rst_n) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      sticky_q <= '0;
      count_q  <= '0;
      limit_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign bus.o_Busy     = (state_q == ST_ARMED);
  assign bus.o_AllDone  = (state_q == ST_DONE);
  assign bus.o_Timeout  = (state_q == ST_TIMEOUT);
  assign bus.o_Pending  = (state_q == ST_ARMED) ? (mask_q & ~sticky_q) : '0;
  assign bus.o_DoneMask = sticky_q;

endmodule

// File: tb/tb_axis_done_barrier.sv
// Directed bench for axis_done_barrier: default 4-channel instance plus a
// 1-channel / 4-bit-timer instance and a 6-channel instance.
module tb_axis_done_barrier;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  axis_done_barrier_if #(.N_CHANNELS(4), .TIMEOUT_WIDTH(24)) b4 ();
  axis_done_barrier_if #(.N_CHANNELS(1), .TIMEOUT_WIDTH(4))  b1 ();
  axis_done_barrier_if #(.N_CHANNELS(6), .TIMEOUT_WIDTH(24)) b6 ();

  axis_done_barrier #(.N_CHANNELS(4), .TIMEOUT_WIDTH(24)) u_dut4 (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(b4));
  axis_done_barrier #(.N_CHANNELS(1), .TIMEOUT_WIDTH(4)) u_dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(b1));
  axis_done_barrier #(.N_CHANNELS(6), .TIMEOUT_WIDTH(24)) u_dut6 (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(b6));

  // Packed status: {busy, all_done, timeout, pending, done_mask}
  logic [10:0] st4;
  logic [4:0]  st1;
  logic [14:0] st6;
  assign st4 = {b4.o_Busy, b4.o_AllDone, b4.o_Timeout, b4.o_Pending, b4.o_DoneMask};
  assign st1 = {b1.o_Busy, b1.o_AllDone, b1.o_Timeout, b1.o_Pending, b1.o_DoneMask};
  assign st6 = {b6.o_Busy, b6.o_AllDone, b6.o_Timeout, b6.o_Pending, b6.o_DoneMask};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input logic s, input logic [3:0] en, input logic [3:0] d,
                      input logic [23:0] t, input logic a, input logic ab);
    b4.i_Start = s; b4.i_Enable = en; b4.i_Done = d;
    b4.i_TimeoutCycles = t; b4.i_Ack = a; b4.i_Abort = ab;
  endtask

  task automatic drv1(input logic s, input logic en, input logic d,
                      input logic [3:0] t, input logic a);
    b1.i_Start = s; b1.i_Enable = en; b1.i_Done = d;
    b1.i_TimeoutCycles = t; b1.i_Ack = a; b1.i_Abort = 1'b0;
  endtask

  task automatic drv6(input logic s, input logic [5:0] en, input logic [5:0] d, input logic a);
    b6.i_Start = s; b6.i_Enable = en; b6.i_Done = d;
    b6.i_TimeoutCycles = '0; b6.i_Ack = a; b6.i_Abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b0, 1'b0);
    drv1(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    drv6(1'b0, 6'h0, 6'h0, 1'b0);
    #12;
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL reset_hold4 got=%b exp=%b", st4, 11'b0); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL reset_rel4 got=%b exp=%b", st4, 11'b0); end
    checks++; if (st1 !== 5'b0) begin failures++; $display("FAIL reset_rel1 got=%b exp=%b", st1, 5'b0); end
    checks++; if (st6 !== 15'b0) begin failures++; $display("FAIL reset_rel6 got=%b exp=%b", st6, 15'b0); end
  endtask

  task automatic test_basic_completion();
    logic [10:0] exp_st [5];
    logic [3:0]  pulses [5];
    exp_st[0] = 11'b100_1111_0000; pulses[0] = 4'b0000;
    exp_st[1] = 11'b100_1110_0001; pulses[1] = 4'b0001;
    exp_st[2] = 11'b100_1100_0011; pulses[2] = 4'b0010;
    exp_st[3] = 11'b100_1000_0111; pulses[3] = 4'b0100;
    exp_st[4] = 11'b010_0000_1111; pulses[4] = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      drv4(i == 0, 4'b1111, pulses[i], 24'd0, 1'b0, 1'b0);
      tick();
      checks++; if (st4 !== exp_st[i]) begin failures++; $display("FAIL basic_step%0d got=%b exp=%b", i, st4, exp_st[i]); end
    end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b0, 1'b0);
    tick(); tick();
    checks++; if (st4 !== 11'b010_0000_1111) begin failures++; $display("FAIL basic_hold got=%b exp=%b", st4, 11'b01000001111); end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b1, 1'b0);
    tick();
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL basic_ack got=%b exp=%b", st4, 11'b0); end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b0, 1'b0);
  endtask

  task automatic test_mask_capture();
    drv4(1'b1, 4'b0101, 4'b0001, 24'd0, 1'b0, 1'b0);
    tick();
    checks++; if (st4 !== 11'b100_0100_0001) begin failures++; $display("FAIL mask_start got=%b exp=%b", st4, 11'b10001000001); end
    drv4(1'b0, 4'b0000, 4'b0010, 24'd0, 1'b0, 1'b0);
    tick();
    checks++; if (st4 !== 11'b100_0100_0001) begin failures++; $display("FAIL mask_ign_y got=%b exp=%b", st4, 11'b10001000001); end
    drv4(1'b0, 4'b0000, 4'b0100, 24'd0, 1'b0, 1'b0);
    tick();
    checks++; if (st4 !== 11'b010_0000_0101) begin failures++; $display("FAIL mask_done_z got=%b exp=%b", st4, 11'b01000000101); end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b1, 1'b0);
    tick();
    drv4(1'b1, 4'b0000, 4'b0000, 24'd0, 1'b0, 1'b0);
    tick();
    checks++; if (st4 !== 11'b010_0000_0000) begin failures++; $display("FAIL mask_zero got=%b exp=%b", st4, 11'b01000000000); end
    // Start coincident with ack is ignored; an accepted empty-mask start would re-enter DONE.
    drv4(1'b1, 4'b0000, 4'b0000, 24'd0, 1'b1, 1'b0);
    tick();
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL ack_start got=%b exp=%b", st4, 11'b0); end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    drv4(1'b1, 4'b1111, 4'b0000, 24'd10, 1'b0, 1'b0);
    tick();
    for (int e = 1; e <= 10; e++) begin
      drv4(1'b0, 4'h0, (e == 1) ? 4'b0001 : 4'b0000, 24'd0, 1'b0, 1'b0);
      tick();
      checks++;
      if (b4.o_Timeout !== (e == 10)) begin
        failures++; $display("FAIL to_edge%0d got=%b exp=%b", e, b4.o_Timeout, (e == 10));
      end
    end
    checks++; if (st4 !== 11'b001_0000_0001) begin failures++; $display("FAIL to_state got=%b exp=%b", st4, 11'b00100000001); end
    drv4(1'b0, 4'h0, 4'b1110, 24'd0, 1'b0, 1'b0);
    tick();
    checks++; if (st4 !== 11'b001_0000_0001) begin failures++; $display("FAIL to_hold got=%b exp=%b", st4, 11'b00100000001); end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b1, 1'b0);
    tick();
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL to_ack got=%b exp=%b", st4, 11'b0); end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b0, 1'b0);
  endtask

  task automatic test_race();
    drv4(1'b1, 4'b0011, 4'b0000, 24'd5, 1'b0, 1'b0);
    tick();
    for (int e = 1; e <= 5; e++) begin
      drv4(1'b0, 4'h0, (e == 1) ? 4'b0001 : ((e == 5) ? 4'b0010 : 4'b0000), 24'd0, 1'b0, 1'b0);
      tick();
      if (e == 4) begin
        checks++; if (st4 !== 11'b100_0010_0001) begin failures++; $display("FAIL race_e4 got=%b exp=%b", st4, 11'b10000100001); end
      end
    end
    checks++; if (st4 !== 11'b010_0000_0011) begin failures++; $display("FAIL race_e5 got=%b exp=%b", st4, 11'b01000000011); end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b1, 1'b0);
    tick();
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    drv4(1'b1, 4'b1111, 4'b0000, 24'd0, 1'b0, 1'b0);
    tick();
    drv4(1'b0, 4'h0, 4'b0001, 24'd0, 1'b0, 1'b0);
    tick();
    drv4(1'b1, 4'b0011, 4'b0000, 24'd0, 1'b0, 1'b0);
    tick();
    checks++; if (st4 !== 11'b100_1110_0001) begin failures++; $display("FAIL start_in_armed got=%b exp=%b", st4, 11'b10011100001); end
    drv4(1'b1, 4'b0000, 4'b1110, 24'd0, 1'b1, 1'b1);
    tick();
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL abort_armed got=%b exp=%b", st4, 11'b0); end
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b0, 1'b0);
    tick();
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL abort_after got=%b exp=%b", st4, 11'b0); end
  endtask

  task automatic test_async_reset();
    drv4(1'b1, 4'b1111, 4'b0001, 24'd0, 1'b0, 1'b0);
    tick();
    drv4(1'b0, 4'h0, 4'h0, 24'd0, 1'b0, 1'b0);
    checks++; if (st4 !== 11'b100_1110_0001) begin failures++; $display("FAIL arst_pre got=%b exp=%b", st4, 11'b10011100001); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL arst_now got=%b exp=%b", st4, 11'b0); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (st4 !== 11'b0) begin failures++; $display("FAIL arst_after got=%b exp=%b", st4, 11'b0); end
  endtask

  task automatic test_params_n1();
    drv1(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    checks++; if (st1 !== 5'b100_1_0) begin failures++; $display("FAIL n1_arm got=%b exp=%b", st1, 5'b10010); end
    drv1(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    checks++; if (st1 !== 5'b010_0_1) begin failures++; $display("FAIL n1_done got=%b exp=%b", st1, 5'b01001); end
    drv1(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    checks++; if (st1 !== 5'b0) begin failures++; $display("FAIL n1_ack got=%b exp=%b", st1, 5'b0); end
    drv1(1'b1, 1'b1, 1'b0, 4'd15, 1'b0);
    tick();
    drv1(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e >= 14) begin
        checks++;
        if (b1.o_Timeout !== (e == 15)) begin
          failures++; $display("FAIL n1_to_edge%0d got=%b exp=%b", e, b1.o_Timeout, (e == 15));
        end
      end
    end
    drv1(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    checks++; if (st1 !== 5'b0) begin failures++; $display("FAIL n1_to_ack got=%b exp=%b", st1, 5'b0); end
    drv1(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_params_n6();
    logic [5:0] pend;
    logic [5:0] dm;
    drv6(1'b1, 6'b111111, 6'b000000, 1'b0);
    tick();
    checks++; if (st6 !== {3'b100, 6'b111111, 6'b000000}) begin failures++; $display("FAIL n6_arm got=%b exp=%b", st6, {3'b100, 6'b111111, 6'b000000}); end
    pend = 6'b111111;
    dm   = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      drv6(1'b0, 6'h0, 6'(1 << i), 1'b0);
      tick();
      pend[i] = 1'b0;
      dm[i]   = 1'b1;
      if (i < 5) begin
        checks++; if (st6 !== {3'b100, pend, dm}) begin failures++; $display("FAIL n6_step%0d got=%b exp=%b", i, st6, {3'b100, pend, dm}); end
      end else begin
        checks++; if (st6 !== {3'b010, 6'b000000, 6'b111111}) begin failures++; $display("FAIL n6_done got=%b exp=%b", st6, {3'b010, 6'b000000, 6'b111111}); end
      end
    end
    drv6(1'b0, 6'h0, 6'h0, 1'b1);
    tick();
    checks++; if (st6 !== 15'b0) begin failures++; $display("FAIL n6_ack got=%b exp=%b", st6, 15'b0); end
    drv6(1'b0, 6'h0, 6'h0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_completion();
    test_mask_capture();
    test_timeout();
    test_race();
    test_abort();
    test_async_reset();
    test_params_n1();
    test_params_n6();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
